// File: rtl/text_ram_ctrl.sv
// Front-end controller for the simple-dual-port text RAM: round-robin write arbitration
// between two requesters, a full-array clear sweep, and a re-timed read-valid strobe.
module text_ram_ctrl #(
    parameter int                    RAM_WIDTH    = 39,
    parameter int                    RAM_DEPTH    = 64,
    parameter int                    ADDR_W       = 6,
    parameter logic [RAM_WIDTH-1:0]  CLEAR_WORD   = {RAM_WIDTH{1'b0}},
    parameter int                    READ_LATENCY = 2
) (
    input  logic                  clka,
    input  logic                  rstb,
    input  logic                  clear_req,
    output logic                  clear_busy,
    input  logic                  wr0_valid,
    output logic                  wr0_ready,
    input  logic [ADDR_W-1:0]     wr0_addr,
    input  logic [RAM_WIDTH-1:0]  wr0_data,
    input  logic                  wr1_valid,
    output logic                  wr1_ready,
    input  logic [ADDR_W-1:0]     wr1_addr,
    input  logic [RAM_WIDTH-1:0]  wr1_data,
    input  logic                  rd_req,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_valid,
    output logic [RAM_WIDTH-1:0]  rd_data,
    output logic [ADDR_W-1:0]     ram_addra,
    output logic [RAM_WIDTH-1:0]  ram_dina,
    output logic                  ram_wea,
    output logic [ADDR_W-1:0]     ram_addrb,
    output logic                  ram_enb,
    output logic                  ram_regceb,
    output logic                  ram_rstb,
    input  logic [RAM_WIDTH-1:0]  ram_doutb
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

    state_t              state;
    logic                rr_ptr;      // 0: wr0 wins a tie, 1: wr1 wins a tie
    logic [ADDR_W-1:0]   clr_addr;
    logic                can_write;
    logic                sel0;
    logic                sel1;
    logic                wr0_fire;
    logic                wr1_fire;
    logic [READ_LATENCY-1:0] rd_pipe;

    // A pending clear request blocks writes in the same cycle so the sweep wins outright.
    assign can_write = (state == IDLE) && !clear_req;
    assign sel0      = wr0_valid && (!wr1_valid || !rr_ptr);
    assign sel1      = wr1_valid && (!wr0_valid ||  rr_ptr);
    assign wr0_ready = can_write && sel0;
    assign wr1_ready = can_write && sel1;
    assign wr0_fire  = wr0_valid && wr0_ready;
    assign wr1_fire  = wr1_valid && wr1_ready;

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation results.
    always_ff @(posedge clka) begin
        if (rstb) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            clr_addr   <= '0;
            clear_busy <= 1'b0;
            ram_wea    <= 1'b0;
            ram_addra  <= '0;
            ram_dina   <= '0;
        end else begin
            ram_wea <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state      <= CLEAR;
                        clear_busy <= 1'b1;
                    end else if (wr0_fire) begin
                        ram_wea   <= 1'b1;
                        ram_addra <= wr0_addr;
                        ram_dina  <= wr0_data;
                        rr_ptr    <= 1'b1;
                    end else if (wr1_fire) begin
                        ram_wea   <= 1'b1;
                        ram_addra <= wr1_addr;
                        ram_dina  <= wr1_data;
                        rr_ptr    <= 1'b0;
                    end
                end
                CLEAR: begin
                    ram_wea   <= 1'b1;
                    ram_addra <= clr_addr;
                    ram_dina  <= CLEAR_WORD;
                    if (clr_addr == LAST_ADDR) begin
                        clr_addr   <= '0;
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read requests go straight to the RAM; only the valid strobe is re-timed.
    assign ram_addrb  = rd_addr;
    assign ram_enb    = rd_req;
    assign ram_regceb = 1'b1;
    assign ram_rstb   = rstb;
    assign rd_data    = ram_doutb;
    assign rd_valid   = rd_pipe[READ_LATENCY-1];

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            always_ff @(posedge clka) begin
                if (rstb) rd_pipe <= '0;
                else      rd_pipe <= rd_req;
            end
        end else begin : g_latn
            always_ff @(posedge clka) begin
                if (rstb) rd_pipe <= '0;
                else      rd_pipe <= {rd_pipe[READ_LATENCY-2:0], rd_req};
            end
        end
    endgenerate

endmodule

// File: doc/text_ram_ctrl.md
Name: text_ram_ctrl

Overview:
Front-end controller for the simple-dual-port text RAM: 39-bit words, 64 entries, 2-cycle read latency in high-performance mode.
- Write side: round-robin arbitration of the RAM write port between two requesters, wr0 (game logic: score/status text) and wr1 (debug/UART loader).
- Clear engine: on request, sweeps every address with a fill word.
- Read side: passes the renderer's read requests to the RAM and re-times them into a read-valid strobe aligned with RAM output data.
- Sits between the requesters/renderer and the RAM; drives all RAM control pins.

Parameters:
RAM_WIDTH, 39, data word width.
RAM_DEPTH, 64, number of RAM entries.
ADDR_W, 6, address width; must equal clog2(RAM_DEPTH).
CLEAR_WORD, {RAM_WIDTH{1'b0}}, value written to every entry during a clear sweep.
READ_LATENCY, 2, RAM read latency in cycles; legal values 1 (low-latency RAM) or 2 (output-registered RAM).

Ports:
clka  in  1  clock
rstb  in  1  reset: synchronous, active-high (controller and RAM output register)
clear_req  in  1  single-cycle request to start a clear sweep
clear_busy  out  1  high while the sweep is in progress
wr0_valid  in  1  requester 0 write request
wr0_ready  out  1  requester 0 grant; a write transfers when valid&ready
wr0_addr  in  ADDR_W  requester 0 address
wr0_data  in  RAM_WIDTH  requester 0 data
wr1_valid  in  1  requester 1 write request
wr1_ready  out  1  requester 1 grant
wr1_addr  in  ADDR_W  requester 1 address
wr1_data  in  RAM_WIDTH  requester 1 data
rd_req  in  1  renderer read request
rd_addr  in  ADDR_W  renderer read address
rd_valid  out  1  rd_data valid
rd_data  out  RAM_WIDTH  read data
ram_addra  out  ADDR_W  RAM write address
ram_dina  out  RAM_WIDTH  RAM write data
ram_wea  out  1  RAM write enable
ram_addrb  out  ADDR_W  RAM read address
ram_enb  out  1  RAM read enable
ram_regceb  out  1  RAM output-register enable
ram_rstb  out  1  RAM output reset
ram_doutb  in  RAM_WIDTH  RAM read data

Behaviour:
- Reset values: state=IDLE; rr_ptr=0 (wr0 favoured); ram_wea=0; ram_addra=0; ram_dina=0; clear_busy=0; clear address counter=0; rd_valid pipeline all 0.
- States: IDLE and CLEAR.
- IDLE, write readiness (combinational):
  - wrN_ready=1 only if state==IDLE, clear_req==0, and wrN is selected.
  - Selection: if only one requester is valid, it is selected. If both are valid, the requester indicated by rr_ptr is selected.
  - After any accepted write, rr_ptr points to the requester that was not served. With no accepted write, rr_ptr holds.
  - At most one ready is high per cycle.
- Write issue: an accepted write registers ram_wea=1, ram_addra=addr, ram_dina=data on the next edge (1-cycle write latency). ram_wea=0 in any cycle without an accepted write or sweep step.
- IDLE -> CLEAR:
  - Triggered by clear_req=1 in IDLE.
  - Clear has priority: both readies are 0 that cycle.
  - clear_busy rises the next cycle.
- CLEAR:
  - Each cycle, register ram_wea=1, ram_addra=counter, ram_dina=CLEAR_WORD; counter increments.
  - Addresses 0..RAM_DEPTH-1 are written in order, exactly one per cycle: 64 consecutive ram_wea pulses.
  - Both readies stay 0 throughout.
  - clear_req during CLEAR is ignored (no restart, no queueing).
  - After address RAM_DEPTH-1 is issued: counter wraps to 0, state returns to IDLE, clear_busy falls on the same edge.
- Read path:
  - Combinational pass-through: ram_addrb=rd_addr, ram_enb=rd_req. ram_regceb tied 1; ram_rstb=rstb.
  - rd_valid = rd_req delayed READ_LATENCY cycles through a shift register; rd_data=ram_doutb.
  - Back-to-back reads are allowed every cycle. Reads are never stalled, including during CLEAR.
  - A read of an address written in the same RAM cycle returns the old contents.
- Reset mid-operation:
  - rstb aborts CLEAR immediately: state=IDLE, clear_busy=0, counter=0. Entries already cleared stay cleared.
  - In-flight rd_valid bits are flushed and the RAM output register is zeroed.
  - rstb has no effect on RAM contents.

Test Plan:
- Round-robin: wr0 and wr1 both valid for 4 cycles after reset, addrs 5/9 -> grants wr0, wr1, wr0, wr1; ram_wea pulses 1 cycle after each grant with matching addr/data.
- Clear sweep: clear_req pulse in IDLE with wr0_valid=1 -> wr0_ready=0; clear_busy high for exactly 64 cycles; ram_addra steps 0..63, all data=0. Subsequent reads of all 64 addresses return 0.
- Write/read latency: write 0x12345 to addr 7, then rd_req addr 7 two cycles later -> rd_valid exactly 2 cycles after rd_req, rd_data=0x12345. With READ_LATENCY=1 -> 1 cycle.
- Ignored request: second clear_req at sweep cycle 30 -> sweep still ends after 64 writes, no restart.
- Reset mid-clear: rstb at sweep address 20 -> next cycle clear_busy=0, ram_wea=0, readies resume. Addr 19 reads 0; addr 21 retains its prior value.
- Single requester: only wr1 valid for 3 cycles -> wr1 granted every cycle, wr0_ready stays 0, rr_ptr ends favouring wr0.
